tt_sweep_ctrl: RTL and testbench

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_pkg.sv | 21 ++
 rtl/tt_sweep_if.sv | 37 +++
 rtl/tt_sweep_cmp.sv | 74 +++++++
 rtl/tt_sweep_ctrl.sv | 113 +++++++++++
 tb/tb_tt_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg -- shared types and defaults for the truth-table sweep controller.
//   sweep_state_e    : controller FSM states
//   TT_IN_W          : default truth-table input width (sweep covers 2^TT_IN_W vectors)
//   TT_OUT_W         : default output word width
//   TT_SETTLE_CYCLES : default settle time of the units under test
// Optional build macro honoured by the design: SWEEP_STOP_ON_ERROR_EN.
package tt_sweep_pkg;

   localparam int TT_IN_W          = 13;
   localparam int TT_OUT_W         = 8;
   localparam int TT_SETTLE_CYCLES = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_APPLY,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } sweep_state_e;

endpackage

// File: rtl/tt_sweep_if.sv
// tt_sweep_if -- sweep-controller bus.
//   master : drives start/abort and returns table word and both unit outputs
//   slave  : the controller; drives the vector, table address, status and results
// Signals: start, abort, dut_x, tbl_addr, tbl_rdata, y_dknf, y_ddnf,
//          busy, done, err_dknf, err_ddnf, err_cnt, first_err_x.
interface tt_sweep_if
   import tt_sweep_pkg::*;
#(
   parameter int IN_W  = TT_IN_W,
   parameter int OUT_W = TT_OUT_W
) ();

   logic              start;
   logic              abort;
   logic [IN_W-1:0]   dut_x;
   logic [IN_W-1:0]   tbl_addr;
   logic [OUT_W-1:0]  tbl_rdata;
   logic [OUT_W-1:0]  y_dknf;
   logic [OUT_W-1:0]  y_ddnf;
   logic              busy;
   logic              done;
   logic              err_dknf;
   logic              err_ddnf;
   logic [IN_W:0]     err_cnt;
   logic [IN_W-1:0]   first_err_x;

   modport master (
      output start, abort, tbl_rdata, y_dknf, y_ddnf,
      input  dut_x, tbl_addr, busy, done, err_dknf, err_ddnf, err_cnt, first_err_x
   );

   modport slave (
      input  start, abort, tbl_rdata, y_dknf, y_ddnf,
      output dut_x, tbl_addr, busy, done, err_dknf, err_ddnf, err_cnt, first_err_x
   );

endinterface

// File: rtl/tt_sweep_cmp.sv
// tt_sweep_cmp -- result checker for the truth-table sweep.
//   clr_i          : clears flags, counter and first-error capture
//   chk_i          : current cycle is a qualified comparison cycle
//   x_i            : vector under test
//   exp_i          : expected word from the table
//   y_dknf_i/_ddnf : outputs of the two units
//   err_*_o        : sticky per-form mismatch flags
//   err_cnt_o      : saturating count of failing vectors
//   first_err_x_o  : first failing vector (valid when err_cnt_o != 0)
//   stop_o         : request to end the sweep now (SWEEP_STOP_ON_ERROR_EN builds only)
module tt_sweep_cmp
   import tt_sweep_pkg::*;
#(
   parameter int IN_W  = TT_IN_W,
   parameter int OUT_W = TT_OUT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             chk_i,
   input  logic [IN_W-1:0]  x_i,
   input  logic [OUT_W-1:0] exp_i,
   input  logic [OUT_W-1:0] y_dknf_i,
   input  logic [OUT_W-1:0] y_ddnf_i,
   output logic             err_dknf_o,
   output logic             err_ddnf_o,
   output logic [IN_W:0]    err_cnt_o,
   output logic [IN_W-1:0]  first_err_x_o,
   output logic             stop_o
);

   logic            miss_k, miss_d, miss_any;
   logic            err_dknf_q, err_ddnf_q;
   logic [IN_W:0]   err_cnt_q, err_cnt_d;
   logic [IN_W-1:0] first_q;

   assign miss_k   = chk_i && (y_dknf_i != exp_i);
   assign miss_d   = chk_i && (y_ddnf_i != exp_i);
   assign miss_any = miss_k || miss_d;

   // one increment per failing vector, regardless of how many forms miss
   assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + (IN_W+1)'(1);

`ifdef SWEEP_STOP_ON_ERROR_EN
   assign stop_o = miss_any;
`else
   assign stop_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_dknf_q <= 1'b0;
         err_ddnf_q <= 1'b0;
         err_cnt_q  <= '0;
         first_q    <= '0;
      end else if (clr_i) begin
         err_dknf_q <= 1'b0;
         err_ddnf_q <= 1'b0;
         err_cnt_q  <= '0;
         first_q    <= '0;
      end else if (miss_any) begin
         err_dknf_q <= err_dknf_q | miss_k;
         err_ddnf_q <= err_ddnf_q | miss_d;
         if (err_cnt_q == '0) first_q <= x_i;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign err_dknf_o    = err_dknf_q;
   assign err_ddnf_o    = err_ddnf_q;
   assign err_cnt_o     = err_cnt_q;
   assign first_err_x_o = first_q;

endmodule

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl -- walks every input vector through two combinational units
// (DKNF and DDNF forms) and compares both against an expected-value table.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : tt_sweep_if.slave (start/abort in, vector/address out,
//              table word and unit outputs in, status and results out)
// Each vector takes APPLY + SETTLE_CYCLES + CHECK cycles. SETTLE_CYCLES is
// legal in 1..15. Defining SWEEP_STOP_ON_ERROR_EN ends the sweep at the first
// failing vector, leaving dut_x on it.
module tt_sweep_ctrl
   import tt_sweep_pkg::*;
#(
   parameter int IN_W          = TT_IN_W,
   parameter int OUT_W         = TT_OUT_W,
   parameter int SETTLE_CYCLES = TT_SETTLE_CYCLES
) (
   input logic       clk,
   input logic       rst,
   tt_sweep_if.slave bus
);

   localparam logic [IN_W-1:0] LAST_IDX = '1;

   sweep_state_e    state_q;
   logic [IN_W-1:0] idx_q;
   logic [3:0]      settle_q;
   logic            busy_q, done_q;
   logic            clr, chk_en, stop_err;

   // abort outranks start, so a coincident pair never launches a sweep
   assign clr    = bus.start && !bus.abort && (state_q == ST_IDLE || state_q == ST_DONE);
   // an aborted CHECK cycle is not scored
   assign chk_en = (state_q == ST_CHECK) && !bus.abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else if (busy_q && bus.abort) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (clr) begin
                  idx_q   <= '0;
                  state_q <= ST_APPLY;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ST_APPLY: begin
               settle_q <= '0;
               state_q  <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_q == 4'(SETTLE_CYCLES - 1)) state_q <= ST_CHECK;
               else                                  settle_q <= settle_q + 4'd1;
            end
            ST_CHECK: begin
               // the last vector finishes the sweep in place; the index never wraps
               if (idx_q == LAST_IDX || stop_err) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + IN_W'(1);
                  state_q <= ST_APPLY;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // the index register itself is the vector, so it holds between APPLYs
   assign bus.dut_x    = idx_q;
   assign bus.tbl_addr = idx_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;

   logic            err_dknf, err_ddnf;
   logic [IN_W:0]   err_cnt;
   logic [IN_W-1:0] first_err_x;

   tt_sweep_cmp #(.IN_W(IN_W), .OUT_W(OUT_W)) u_cmp (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (clr),
      .chk_i        (chk_en),
      .x_i          (idx_q),
      .exp_i        (bus.tbl_rdata),
      .y_dknf_i     (bus.y_dknf),
      .y_ddnf_i     (bus.y_ddnf),
      .err_dknf_o   (err_dknf),
      .err_ddnf_o   (err_ddnf),
      .err_cnt_o    (err_cnt),
      .first_err_x_o(first_err_x),
      .stop_o       (stop_err)
   );

   assign bus.err_dknf    = err_dknf;
   assign bus.err_ddnf    = err_ddnf;
   assign bus.err_cnt     = err_cnt;
   assign bus.first_err_x = first_err_x;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl -- self-checking bench for tt_sweep_ctrl.
// A sweep-level model (cycle count since start, per-vector fault lists) is
// compared against the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations. Honours SWEEP_STOP_ON_ERROR_EN.
module tb_tt_sweep_ctrl;
   import tt_sweep_pkg::*;

   localparam int IN_W  = 13;
   localparam int OUT_W = 8;
   localparam int SC    = 2;
   localparam int P     = SC + 2;
   localparam int N     = 1 << IN_W;
   localparam logic [13:0] NONE = 14'h2000;
`ifdef SWEEP_STOP_ON_ERROR_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tt_sweep_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
   tt_sweep_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE_CYCLES(SC)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // fault injection: table word corrupted at tbad, y_dknf bit 3 inverted at dk0/dk1
   logic [13:0] tbad = NONE, dk0 = NONE, dk1 = NONE;

   function automatic logic [7:0] gold(input logic [12:0] x);
      return x[7:0] ^ {x[12:8], x[2:0]} ^ 8'h3C;
   endfunction

   assign bus.y_ddnf = gold(bus.dut_x);
   assign bus.y_dknf = gold(bus.dut_x) ^
                       ((({1'b0, bus.dut_x} == dk0) || ({1'b0, bus.dut_x} == dk1)) ? 8'h08 : 8'h00);
   always @(posedge clk)
      bus.tbl_rdata <= gold(bus.tbl_addr) ^ (({1'b0, bus.tbl_addr} == tbad) ? 8'hFF : 8'h00);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- sweep-level model ----------------
   function automatic bit bad_k(input int v);
      return (v == int'(tbad)) || (v == int'(dk0)) || (v == int'(dk1));
   endfunction
   function automatic bit bad_d(input int v);
      return v == int'(tbad);
   endfunction

   bit m_run = 0, m_done = 0, m_fk = 0, m_fd = 0;
   int m_c = 0, m_x = 0, m_cnt = 0, m_first = 0;
   int chk_v;
   bit chk_any;
   // vector whose verdict lands on the coming edge (meaningful when (m_c+1)%P==0)
   always_comb chk_v   = (m_c + 1) / P - 1;
   always_comb chk_any = bad_k(chk_v) || bad_d(chk_v);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run <= 0; m_done <= 0; m_c <= 0; m_x <= 0;
         m_cnt <= 0; m_fk <= 0; m_fd <= 0; m_first <= 0;
      end else if (m_run && bus.abort) begin
         m_run <= 0;
      end else if (m_run) begin
         m_c <= m_c + 1;
         if ((m_c + 1) % P == 0) begin
            if (chk_any) begin
               m_fk  <= m_fk | bad_k(chk_v);
               m_fd  <= m_fd | bad_d(chk_v);
               m_cnt <= m_cnt + 1;
               if (m_cnt == 0) m_first <= chk_v;
            end
            if (chk_v == N - 1 || (STOP && chk_any)) begin
               m_run <= 0; m_done <= 1; m_x <= chk_v;
            end else begin
               m_x <= chk_v + 1;
            end
         end
      end else if (bus.start && !bus.abort) begin
         m_run <= 1; m_done <= 0; m_c <= 0; m_x <= 0;
         m_cnt <= 0; m_fk <= 0; m_fd <= 0;
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(bus.busy), 32'(m_run));
      chk("done", 32'(bus.done), 32'(m_done));
      chk("dut_x", 32'(bus.dut_x), m_x);
      chk("tbl_addr", 32'(bus.tbl_addr), m_x);
      chk("err_dknf", 32'(bus.err_dknf), 32'(m_fk));
      chk("err_ddnf", 32'(bus.err_ddnf), 32'(m_fd));
      chk("err_cnt", 32'(bus.err_cnt), m_cnt);
      if (m_cnt != 0) chk("first_err_x", 32'(bus.first_err_x), m_first);
   end

   // ---------------- directed stimulus ----------------
   // called on a falling edge; returns on the falling edge after the start edge
   task automatic pulse_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic pulse_abort();
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (bus.done !== 1'b1 && n < max) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_x(input logic [12:0] x, input int max);
      int n = 0;
      while (bus.dut_x !== x && n < max) begin
         @(negedge clk);
         n++;
      end
      chk("reach_x", 32'(bus.dut_x), 32'(x));
   endtask

   initial begin
      int n;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 0);
      chk("rst_dut_x", 32'(bus.dut_x), 0);
      repeat (4) @(negedge clk);
      chk("no_autostart", 32'(bus.busy), 0);

      // abort during SETTLE of vector 0x40, results retained
      dk0 = STOP ? NONE : 14'h0010;
      pulse_start();
      wait_x(13'h040, 400);
      @(negedge clk);                  // first SETTLE cycle of 0x40
      pulse_abort();
      chk("abort_busy", 32'(bus.busy), 0);
      chk("abort_done", 32'(bus.done), 0);
      chk("abort_dut_x", 32'(bus.dut_x), 32'h40);
      chk("abort_err_cnt", 32'(bus.err_cnt), STOP ? 0 : 1);
      chk("abort_err_dknf", 32'(bus.err_dknf), STOP ? 0 : 1);
      chk("abort_err_ddnf", 32'(bus.err_ddnf), 0);
      // abort and start together: start is ignored
      bus.start = 1'b1; bus.abort = 1'b1;
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      chk("abort_wins_busy", 32'(bus.busy), 0);
      chk("abort_wins_cnt", 32'(bus.err_cnt), STOP ? 0 : 1);
      // a fresh start clears the results
      pulse_start();
      chk("restart_cnt", 32'(bus.err_cnt), 0);
      chk("restart_dknf", 32'(bus.err_dknf), 0);
      chk("restart_busy", 32'(bus.busy), 1);
      chk("restart_dut_x", 32'(bus.dut_x), 0);
      pulse_abort();
      dk0 = NONE;

      // reset asserted in the CHECK cycle of vector 5
      pulse_start();
      wait_x(13'h005, 100);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rstmid_busy", 32'(bus.busy), 0);
      chk("rstmid_done", 32'(bus.done), 0);
      chk("rstmid_dut_x", 32'(bus.dut_x), 0);
      chk("rstmid_tbl_addr", 32'(bus.tbl_addr), 0);
      chk("rstmid_err_cnt", 32'(bus.err_cnt), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk("rstmid_no_done", 32'(bus.done), 0);
      chk("rstmid_idle", 32'(bus.busy), 0);

`ifndef SWEEP_STOP_ON_ERROR_EN
      // corrupted table word 0x0A5, aborted once its verdict is in
      tbad = 14'h00A5;
      pulse_start();
      wait_x(13'h0A6, 1000);
      pulse_abort();
      chk("tbl_err_cnt", 32'(bus.err_cnt), 1);
      chk("tbl_err_dknf", 32'(bus.err_dknf), 1);
      chk("tbl_err_ddnf", 32'(bus.err_ddnf), 1);
      chk("tbl_first", 32'(bus.first_err_x), 32'h0A5);
      tbad = NONE;
`endif

      // clean full sweep
      pulse_start();
      wait_done(40000, n);
      chk("clean_cycles", n, 32768);
      chk("clean_err_cnt", 32'(bus.err_cnt), 0);
      chk("clean_err_dknf", 32'(bus.err_dknf), 0);
      chk("clean_err_ddnf", 32'(bus.err_ddnf), 0);
      chk("clean_last_x", 32'(bus.dut_x), 32'h1FFF);
      repeat (3) @(negedge clk);
      chk("done_holds", 32'(bus.done), 1);

`ifdef SWEEP_STOP_ON_ERROR_EN
      // stop at the first failing vector 0x7
      dk0 = 14'h0007;
      pulse_start();
      wait_done(1000, n);
      chk("stop_cycles", n, 8 * P);
      chk("stop_dut_x", 32'(bus.dut_x), 32'h7);
      chk("stop_err_cnt", 32'(bus.err_cnt), 1);
      chk("stop_done", 32'(bus.done), 1);
`else
      // y_dknf bit 3 inverted at 0x100 and the final vector
      dk0 = 14'h0100; dk1 = 14'h1FFF;
      pulse_start();
      wait_done(40000, n);
      chk("dk_cycles", n, 32768);
      chk("dk_err_cnt", 32'(bus.err_cnt), 2);
      chk("dk_err_dknf", 32'(bus.err_dknf), 1);
      chk("dk_err_ddnf", 32'(bus.err_ddnf), 0);
      chk("dk_first", 32'(bus.first_err_x), 32'h100);
      chk("dk_last_x", 32'(bus.dut_x), 32'h1FFF);
`endif

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
